// File: rtl/sar_result_capture_if.sv
// Output stream of sar_result_capture: averaged word at the FIFO head with valid/ready.
// out_tstamp exists only when SAR_CAPTURE_TIMESTAMP_EN is defined.
interface sar_result_capture_if #(
  parameter int DATA_W = 11
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
`ifdef SAR_CAPTURE_TIMESTAMP_EN
  logic [15:0]       out_tstamp;
`endif

  modport master (
    output out_data,
    output out_valid,
`ifdef SAR_CAPTURE_TIMESTAMP_EN
    output out_tstamp,
`endif
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
`ifdef SAR_CAPTURE_TIMESTAMP_EN
    input  out_tstamp,
`endif
    output out_ready
  );
endinterface

// File: rtl/sar_result_capture.sv
// Captures SAR results on conv_done rising edges, averages 2^AVG_LOG2 samples (round-half-up)
// and streams them through a small FIFO with drop accounting. Optional: SAR_CAPTURE_TIMESTAMP_EN.
module sar_result_capture #(
  parameter int DATA_W     = 11,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        conv_done,
  input  logic [DATA_W-1:0]           result,
  input  logic                        clr_status,
  sar_result_capture_if.master        out_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  drop_count
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
  localparam logic [ACC_W-1:0] ROUND    = ACC_W'((2 ** AVG_LOG2) / 2);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic              done_d_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              valid_r;
  logic              overflow_r;
  logic [7:0]        drop_cnt_r;

  logic              edge_s;
  logic              final_s;
  logic [ACC_W-1:0]  sum_s;
  logic [DATA_W-1:0] push_word_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              wr_en_s;
  logic              drop_s;
  logic [LVL_W-1:0]  level_nxt_s;
  logic [7:0]        drop_base_s;
  logic [7:0]        drop_nxt_s;
  logic              ovf_nxt_s;

  // Edge detection, averaging datapath and FIFO/status next-state decode.
  always_comb begin
    edge_s      = conv_done & ~done_d_r & enable;
    final_s     = (cnt_r == CNT_LAST);
    // Sum of 2^AVG_LOG2 DATA_W-bit samples plus half an LSB always fits in ACC_W.
    sum_s       = acc_r + ACC_W'(result);
    push_word_s = DATA_W'((sum_s + ROUND) >> AVG_LOG2);
    push_s      = edge_s & final_s;
    pop_s       = valid_r & out_if.out_ready;
    full_s      = (level_r == LVL_FULL);
    wr_en_s     = push_s & (~full_s | pop_s);
    drop_s      = push_s & full_s & ~pop_s;

    if (wr_en_s && !pop_s) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else if (pop_s && !wr_en_s) begin
      level_nxt_s = level_r - LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end

    // The clear takes effect before a coincident drop is counted.
    if (clr_status) begin
      drop_base_s = 8'd0;
    end else begin
      drop_base_s = drop_cnt_r;
    end
    if (drop_s && (drop_base_s != 8'hFF)) begin
      drop_nxt_s = drop_base_s + 8'd1;
    end else begin
      drop_nxt_s = drop_base_s;
    end
    if (drop_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_status) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = overflow_r;
    end
  end

  // Edge history and accumulator; done_d resets high so a level already high at release is no edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_d_r <= 1'b1;
      acc_r    <= '0;
      cnt_r    <= '0;
    end else begin
      done_d_r <= conv_done;
      if (!enable) begin
        acc_r <= '0;
        cnt_r <= '0;
      end else if (edge_s && !final_s) begin
        acc_r <= sum_s;
        cnt_r <= cnt_r + CNT_W'(1);
      end else if (edge_s) begin
        acc_r <= '0;
        cnt_r <= '0;
      end else begin
        acc_r <= acc_r;
        cnt_r <= cnt_r;
      end
    end
  end

  // FIFO storage, pointers, occupancy and sticky status.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_word_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r    <= level_nxt_s;
      valid_r    <= (level_nxt_s != '0);
      overflow_r <= ovf_nxt_s;
      drop_cnt_r <= drop_nxt_s;
    end
  end

`ifdef SAR_CAPTURE_TIMESTAMP_EN
  logic [15:0] tstamp_r;
  logic [15:0] ts_mem_r [FIFO_DEPTH];

  // Free-running timestamp; the final-sample edge cycle value travels with its word.
  always_ff @(posedge clock) begin
    if (reset) begin
      tstamp_r <= 16'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ts_mem_r[i] <= 16'd0;
      end
    end else begin
      tstamp_r <= tstamp_r + 16'd1;
      if (wr_en_s) begin
        ts_mem_r[wr_ptr_r] <= tstamp_r;
      end
    end
  end

  assign out_if.out_tstamp = ts_mem_r[rd_ptr_r];
`endif

  assign out_if.out_data  = mem_r[rd_ptr_r];
  assign out_if.out_valid = valid_r;
  assign fifo_level       = level_r;
  assign overflow         = overflow_r;
  assign drop_count       = drop_cnt_r;

endmodule

// File: tb/tb_sar_result_capture.sv
// Directed bench for sar_result_capture: averaging instance (AVG_LOG2=2) plus a pass-through one (AVG_LOG2=0).
module tb_sar_result_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, enable0;
  logic        conv_done, conv_done0;
  logic [10:0] result, result0;
  logic        clr_status, clr_status0;
  logic [2:0]  fifo_level, fifo_level0;
  logic        overflow, overflow0;
  logic [7:0]  drop_count, drop_count0;

  int errors = 0;
  int checks = 0;

  sar_result_capture_if #(.DATA_W(11)) sif  ();
  sar_result_capture_if #(.DATA_W(11)) sif0 ();

  sar_result_capture #(.DATA_W(11), .AVG_LOG2(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .conv_done(conv_done),
    .result(result), .clr_status(clr_status), .out_if(sif.master),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
  );

  sar_result_capture #(.DATA_W(11), .AVG_LOG2(0), .FIFO_DEPTH(4)) dut0 (
    .clock(clock), .reset(reset), .enable(enable0), .conv_done(conv_done0),
    .result(result0), .clr_status(clr_status0), .out_if(sif0.master),
    .fifo_level(fifo_level0), .overflow(overflow0), .drop_count(drop_count0)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [10:0] s0;
    logic [10:0] s1;
    logic [10:0] s2;
    logic [10:0] s3;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [10:0] r);
    conv_done = 1'b1;
    result    = r;
    tick();
    conv_done = 1'b0;
    tick();
  endtask

  task automatic push_avg(input logic [10:0] v);
    for (int k = 0; k < 4; k++) pulse(v);
  endtask

  task automatic pop_one();
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
  endtask

  initial begin
    logic [10:0] drain_exp [4];

    vecs[0] = '{11'd1,   11'd2,   11'd3,   11'd4,   11'd3};
    vecs[1] = '{11'd1,   11'd1,   11'd1,   11'd2,   11'd1};
    vecs[2] = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
    vecs[3] = '{11'd0,   11'd0,   11'd1,   11'd1,   11'd1};
    vecs[4] = '{11'd0,   11'd0,   11'd0,   11'd1,   11'd0};
    vecs[5] = '{11'd5,   11'd5,   11'd5,   11'd6,   11'd5};
    vecs[6] = '{11'd3,   11'd3,   11'd3,   11'd3,   11'd3};
    vecs[7] = '{11'd100, 11'd200, 11'd300, 11'd401, 11'd250};

    reset = 1'b1; enable = 1'b1; enable0 = 1'b1;
    conv_done = 1'b1; conv_done0 = 1'b1;
    result = 11'd0; result0 = 11'd0;
    clr_status = 1'b0; clr_status0 = 1'b0;
    sif.out_ready = 1'b0; sif0.out_ready = 1'b1;

    // Reset with conv_done held high: no edge after release.
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid0_a", 32'(sif0.out_valid), 32'd0);
    tick();
    chk("rst_valid0_b", 32'(sif0.out_valid), 32'd0);
    chk("rst_level0",   32'(fifo_level0),    32'd0);
    chk("rst_valid",    32'(sif.out_valid),  32'd0);
    chk("rst_data",     32'(sif.out_data),   32'd0);
    chk("rst_level",    32'(fifo_level),     32'd0);
    chk("rst_ovf",      32'(overflow),       32'd0);
    chk("rst_drops",    32'(drop_count),     32'd0);
    conv_done = 1'b0; conv_done0 = 1'b0;
    tick();

    // Pass-through instance: one-cycle latency, single word.
    conv_done0 = 1'b1; result0 = 11'h2A5;
    tick();
    chk("p0_valid", 32'(sif0.out_valid), 32'd1);
    chk("p0_data",  32'(sif0.out_data),  32'h2A5);
    tick();
    chk("p0_valid_next", 32'(sif0.out_valid), 32'd0);
    conv_done0 = 1'b0;
    tick();

    // Averaging table.
    for (int i = 0; i < 8; i++) begin
      pulse(vecs[i].s0);
      pulse(vecs[i].s1);
      pulse(vecs[i].s2);
      chk($sformatf("vec%0d_pre_valid", i), 32'(sif.out_valid), 32'd0);
      conv_done = 1'b1; result = vecs[i].s3;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(sif.out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  32'(sif.out_data),  32'(vecs[i].exp));
      conv_done = 1'b0;
      pop_one();
      chk($sformatf("vec%0d_popped", i), 32'(sif.out_valid), 32'd0);
    end

    // conv_done held high for 10 cycles counts once.
    conv_done = 1'b1; result = 11'd4;
    repeat (10) tick();
    conv_done = 1'b0;
    tick();
    chk("hold_level", 32'(fifo_level), 32'd0);
    pulse(11'd4);
    pulse(11'd4);
    chk("hold_level2", 32'(fifo_level), 32'd0);
    conv_done = 1'b1;
    tick();
    chk("hold_valid", 32'(sif.out_valid), 32'd1);
    chk("hold_data",  32'(sif.out_data),  32'd4);
    conv_done = 1'b0;
    pop_one();

    // Overflow: six words into a 4-deep FIFO with no consumer.
    push_avg(11'd10); push_avg(11'd20); push_avg(11'd30);
    push_avg(11'd40); push_avg(11'd50); push_avg(11'd60);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag",  32'(overflow),   32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd2);
    chk("ovf_head",  32'(sif.out_data), 32'd10);

    // Push and pop together while full: nothing dropped.
    pulse(11'd70); pulse(11'd70); pulse(11'd70);
    conv_done = 1'b1; result = 11'd70; sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0; conv_done = 1'b0;
    tick();
    chk("pp_level", 32'(fifo_level), 32'd4);
    chk("pp_drops", 32'(drop_count), 32'd2);
    drain_exp = '{11'd20, 11'd30, 11'd40, 11'd70};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(sif.out_data), 32'(drain_exp[i]));
      pop_one();
    end
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_valid", 32'(sif.out_valid), 32'd0);

    // clr_status coincident with a drop.
    push_avg(11'd1); push_avg(11'd2); push_avg(11'd3); push_avg(11'd4);
    pulse(11'd5); pulse(11'd5); pulse(11'd5);
    conv_done = 1'b1; result = 11'd5; clr_status = 1'b1;
    tick();
    clr_status = 1'b0; conv_done = 1'b0;
    chk("clrdrop_flag",  32'(overflow),   32'd1);
    chk("clrdrop_drops", 32'(drop_count), 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clr_flag",  32'(overflow),   32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);
    chk("clr_level", 32'(fifo_level), 32'd4);
    repeat (4) pop_one();
    chk("clr_drained", 32'(fifo_level), 32'd0);

    // Partial average discarded by enable=0.
    pulse(11'd100); pulse(11'd100);
    enable = 1'b0;
    tick(); tick(); tick();
    enable = 1'b1;
    pulse(11'd8); pulse(11'd8); pulse(11'd8);
    chk("en_pre_level", 32'(fifo_level), 32'd0);
    pulse(11'd8);
    chk("en_level", 32'(fifo_level), 32'd1);
    chk("en_data",  32'(sif.out_data), 32'd8);
    pop_one();

    // Edges while disabled are ignored.
    enable = 1'b0;
    push_avg(11'd9);
    chk("dis_level", 32'(fifo_level), 32'd0);
    enable = 1'b1;

    // Reset mid-stream discards FIFO contents and status.
    push_avg(11'd12);
    pulse(11'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_valid", 32'(sif.out_valid), 32'd0);
    chk("mrst_data",  32'(sif.out_data), 32'd0);
    tick();
    push_avg(11'd6);
    chk("mrst_avg", 32'(sif.out_data), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
